// File: rtl/usr_pkg.sv
// usr_pkg: op codes and FSM state encodings shared by the universal shift register.
package usr_pkg;
    localparam logic [2:0] OP_HOLD  = 3'd0;
    localparam logic [2:0] OP_SHR   = 3'd1;
    localparam logic [2:0] OP_SHL   = 3'd2;
    localparam logic [2:0] OP_LOAD  = 3'd3;
    localparam logic [2:0] OP_ROR   = 3'd4;
    localparam logic [2:0] OP_ROL   = 3'd5;
    localparam logic [2:0] OP_ASR   = 3'd6;
    localparam logic [2:0] OP_CLEAR = 3'd7;
    typedef enum logic {ST_IDLE, ST_SHIFT} state_t;
endpackage

// File: rtl/universal_sr_step.sv
// universal_sr_step: combinational single-step next value and outgoing bit for one op.
module universal_sr_step
    import usr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] cur,
    input  logic [WIDTH-1:0] p_in,
    input  logic             r_in,
    input  logic             l_in,
    output logic [WIDTH-1:0] nxt,
    output logic             out_bit
);
    always_comb begin
        nxt     = cur;
        out_bit = 1'b0;
        case (op)
            OP_SHR:   begin nxt = {r_in, cur[WIDTH-1:1]};          out_bit = cur[0];       end
            OP_SHL:   begin nxt = {cur[WIDTH-2:0], l_in};          out_bit = cur[WIDTH-1]; end
            OP_ROR:   begin nxt = {cur[0], cur[WIDTH-1:1]};        out_bit = cur[0];       end
            OP_ROL:   begin nxt = {cur[WIDTH-2:0], cur[WIDTH-1]};  out_bit = cur[WIDTH-1]; end
            OP_ASR:   begin nxt = {cur[WIDTH-1], cur[WIDTH-1:1]};  out_bit = cur[0];       end
            OP_LOAD:  nxt = p_in;
            OP_CLEAR: nxt = '0;
            default:  ;
        endcase
    end
endmodule

// File: rtl/universal_sr_seq.sv
// universal_sr_seq: multi-cycle universal shift register; shifts/rotates advance one bit
// per clock for a clamped step count, with busy/done handshake.
module universal_sr_seq
    import usr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [CNT_W-1:0] amount,
    input  logic [WIDTH-1:0] p_in,
    input  logic             r_in,
    input  logic             l_in,
    output logic [WIDTH-1:0] p_out,
    output logic             so,
    output logic             busy,
    output logic             done
);
    localparam logic [CNT_W-1:0] W_C = CNT_W'(WIDTH);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n, eff;
    logic [2:0]       op_q, op_n, step_op;
    logic [WIDTH-1:0] p_n, nxt;
    logic             so_n, busy_n, done_n, out_bit, multi;

    assign eff     = (amount > W_C) ? W_C : amount;
    assign multi   = !(op inside {OP_HOLD, OP_LOAD, OP_CLEAR});
    // Live op drives the step block in IDLE for single-cycle ops; latched op while shifting.
    assign step_op = (state == ST_SHIFT) ? op_q : op;

    universal_sr_step #(.WIDTH(WIDTH)) u_step (
        .op(step_op),
        .cur(p_out),
        .p_in(p_in),
        .r_in(r_in),
        .l_in(l_in),
        .nxt(nxt),
        .out_bit(out_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            op_q  <= OP_HOLD;
            p_out <= '0;
            so    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            op_q  <= op_n;
            p_out <= p_n;
            so    <= so_n;
            busy  <= busy_n;
            done  <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        op_n    = op_q;
        p_n     = p_out;
        so_n    = so;
        busy_n  = busy;
        done_n  = 1'b0;
        if (state == ST_IDLE) begin
            if (start && !multi) begin
                p_n    = nxt;
                done_n = 1'b1;
            end else if (start && eff == '0) begin
                done_n = 1'b1;
            end else if (start) begin
                op_n    = op;
                cnt_n   = eff;
                busy_n  = 1'b1;
                state_n = ST_SHIFT;
            end
        end else begin
            p_n   = nxt;
            so_n  = out_bit;
            cnt_n = cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
                state_n = ST_IDLE;
                busy_n  = 1'b0;
                done_n  = 1'b1;
            end
        end
    end
endmodule
